// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, ALU op encoding and controller states shared by the packet controller
package alu_pkg;
  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD = 8'hAD;
  localparam logic [7:0] OP_MUL = 8'h88;
  localparam logic [7:0] OP_DIV = 8'hD0;
  localparam int HDR_BYTES = 4;
  typedef enum logic [1:0] {ADD = 2'd0, MUL = 2'd1, DIV = 2'd2} alu_op_e;
  typedef enum logic [3:0] {
    HDR_OP, HDR_RSV, HDR_LLO, HDR_LHI, ECHO, DRAIN, WORD, ALU_REQ, ALU_WAIT, TX_RES
  } ctrl_state_e;
  function automatic alu_op_e op_map(input logic [7:0] opcode);
    return opcode == OP_MUL ? MUL : opcode == OP_DIV ? DIV : ADD;
  endfunction
  function automatic logic is_arith(input logic [7:0] opcode);
    return opcode == OP_ADD || opcode == OP_MUL || opcode == OP_DIV;
  endfunction
endpackage

// File: rtl/byte_word_pack.sv
// byte_word_pack: little-endian 4-byte shift register with a strobe on the fourth byte
module byte_word_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_done
);
  logic [23:0] sh;
  logic [1:0] cnt;
  assign word = {in_data, sh};
  assign word_done = in_valid && cnt == 2'd3;
  always_ff @(posedge clk)
    if (rst) begin
      sh <= '0;
      cnt <= '0;
    end else if (in_valid) begin
      sh <= {in_data, sh[23:8]};
      cnt <= cnt + 2'd1;
    end
endmodule

// File: rtl/alu_packet_ctrl.sv
// alu_packet_ctrl: parses UART packets, echoes payload or folds payload words through the external ALU
module alu_packet_ctrl
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [1:0]  alu_op_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic        alu_valid_o,
  input  logic        alu_ready_i,
  input  logic [31:0] alu_result_i,
  input  logic        alu_result_valid_i,
  output logic        busy_o,
  output logic        err_o
);
  ctrl_state_e state, state_n;
  logic [7:0] opcode, len_lo;
  logic [15:0] cnt, len, pay;
  logic [31:0] acc, word_q, word;
  logic [1:0] tx_idx;
  logic first, rx_fire, tx_fire, word_done, short_len, bad;
  assign len = {rx_data_i, len_lo};
  assign pay = len - 16'(HDR_BYTES);
  assign short_len = len < 16'(HDR_BYTES);
  assign bad = short_len || (opcode != OP_ECHO && (!is_arith(opcode) || pay == '0 || pay[1:0] != 2'b00));
  assign rx_ready_o = state == ECHO ? tx_ready_i : !(state inside {ALU_REQ, ALU_WAIT, TX_RES});
  assign tx_valid_o = state == ECHO ? rx_valid_i : state == TX_RES;
  assign tx_data_o = state == ECHO ? rx_data_i : state == TX_RES ? 8'(acc >> {tx_idx, 3'b000}) : 8'h00;
  assign rx_fire = rx_valid_i && rx_ready_o;
  assign tx_fire = tx_valid_o && tx_ready_i;
  assign alu_valid_o = state == ALU_REQ;
  assign alu_a_o = acc;
  assign alu_b_o = word_q;
  assign alu_op_o = op_map(opcode);
  assign busy_o = state != HDR_OP;
  byte_word_pack u_pack (
    .clk(clk),
    .rst(rst),
    .in_valid(rx_fire && state == WORD),
    .in_data(rx_data_i),
    .word(word),
    .word_done(word_done)
  );
  always_ff @(posedge clk)
    state <= rst ? HDR_OP : state_n;
  always_comb begin
    state_n = state;
    case (state)
      HDR_OP:   state_n = rx_fire ? HDR_RSV : HDR_OP;
      HDR_RSV:  state_n = rx_fire ? HDR_LLO : HDR_RSV;
      HDR_LLO:  state_n = rx_fire ? HDR_LHI : HDR_LLO;
      HDR_LHI:  if (rx_fire)
                  state_n = bad ? (short_len || pay == '0 ? HDR_OP : DRAIN)
                          : opcode == OP_ECHO ? (pay == '0 ? HDR_OP : ECHO) : WORD;
      ECHO, DRAIN: state_n = rx_fire && cnt == 16'd1 ? HDR_OP : state;
      WORD:     if (word_done) state_n = !first ? ALU_REQ : cnt == 16'd1 ? TX_RES : WORD;
      ALU_REQ:  state_n = alu_ready_i ? ALU_WAIT : ALU_REQ;
      ALU_WAIT: if (alu_result_valid_i) state_n = cnt == '0 ? TX_RES : WORD;
      TX_RES:   state_n = tx_fire && tx_idx == 2'd3 ? HDR_OP : TX_RES;
      default:  state_n = HDR_OP;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      opcode <= '0;
      len_lo <= '0;
      cnt <= '0;
      acc <= '0;
      word_q <= '0;
      tx_idx <= '0;
      first <= 1'b0;
      err_o <= 1'b0;
    end else begin
      err_o <= state == HDR_LHI && rx_fire && bad;
      if (state == HDR_OP && rx_fire) opcode <= rx_data_i;
      if (state == HDR_LLO && rx_fire) len_lo <= rx_data_i;
      if (state == HDR_LHI && rx_fire) begin
        cnt <= pay;
        first <= 1'b1;
        tx_idx <= '0;
      end
      if (rx_fire && state inside {ECHO, DRAIN, WORD}) cnt <= cnt - 16'd1;
      if (state == WORD && word_done) begin
        first <= 1'b0;
        if (first) acc <= word;
        else word_q <= word;
      end
      if (state == ALU_WAIT && alu_result_valid_i) acc <= alu_result_i;
      if (state == TX_RES && tx_fire) tx_idx <= tx_idx + 2'd1;
    end
endmodule
